// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - turn/advance sequencer for a multi-player card-flip board game
//
// Ports:
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        level request to begin a game (accepted in IDLE or DONE)
//   num_players  player count minus one, sampled when start is accepted (0 -> 2 players)
//   flip         one-cycle pulse: current player turned over a card
//   match        qualifies flip: card matched the target tile
//   W            win flag from the position datapath, valid the cycle after B
//   T            index of the current player
//   B            one-cycle advance strobe for player T
//   streak       consecutive matches in the current turn, saturating at 31
//   game_over    high while the game is finished
//   winner       index of the winning player, valid while game_over=1
module turn_sequencer #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] num_players,
  input  logic       flip,
  input  logic       match,
  input  logic       W,
  output logic [1:0] T,
  output logic       B,
  output logic [4:0] streak,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ADV,
    CHECK,
    PASS,
    DONE
  } state_t;

  // Timer value on which an idle player loses the turn.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  t_q, t_d;
  logic        b_q, b_d;
  logic [4:0]  streak_q, streak_d;
  logic        over_q, over_d;
  logic [1:0]  winner_q, winner_d;
  logic [15:0] timer_q, timer_d;
  // Index of the last active player; 0 on the port still means two players.
  logic [1:0]  last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= 2'd0;
      b_q      <= 1'b0;
      streak_q <= 5'd0;
      over_q   <= 1'b0;
      winner_q <= 2'd0;
      timer_q  <= 16'd0;
      last_q   <= 2'd1;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      b_q      <= b_d;
      streak_q <= streak_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      timer_q  <= timer_d;
      last_q   <= last_d;
    end
  end

  // Next-state and next-output logic. Every output is a register, so the
  // values computed here for the transition into a state are what that state
  // presents (e.g. B is high for exactly the ADV cycle).
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    b_d      = 1'b0;
    streak_d = streak_q;
    over_d   = over_q;
    winner_d = winner_q;
    timer_d  = timer_q;
    last_d   = last_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = WAIT;
          last_d   = (num_players == 2'd0) ? 2'd1 : num_players;
          t_d      = 2'd0;
          streak_d = 5'd0;
          timer_d  = 16'd0;
          over_d   = 1'b0;
          winner_d = 2'd0;
        end
      end

      WAIT: begin
        // A flip on the timeout cycle is checked first so it wins.
        if (flip) begin
          timer_d = 16'd0;
          if (match) begin
            state_d  = ADV;
            b_d      = 1'b1;
            streak_d = (streak_q == 5'd31) ? streak_q : streak_q + 5'd1;
          end else begin
            state_d = PASS;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = PASS;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ADV: begin
        state_d = CHECK;
      end

      CHECK: begin
        if (W) begin
          state_d  = DONE;
          over_d   = 1'b1;
          winner_d = t_q;
        end else begin
          state_d = WAIT;
          timer_d = 16'd0;
        end
      end

      PASS: begin
        state_d  = WAIT;
        t_d      = (t_q == last_q) ? 2'd0 : t_q + 2'd1;
        streak_d = 5'd0;
        timer_d  = 16'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign T         = t_q;
  assign B         = b_q;
  assign streak    = streak_q;
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer
module tb_turn_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] num_players;
  logic       flip;
  logic       match;
  logic       W;
  logic [1:0] T;
  logic       B;
  logic [4:0] streak;
  logic       game_over;
  logic [1:0] winner;

  int errors;
  int checks;

  turn_sequencer #(.TIMEOUT(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_players (num_players),
    .flip        (flip),
    .match       (match),
    .W           (W),
    .T           (T),
    .B           (B),
    .streak      (streak),
    .game_over   (game_over),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; flip = 1'b0; match = 1'b0; W = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic begin_game(input logic [1:0] np);
    num_players = np; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    num_players = 2'd0;
    do_reset();
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL reset_T: got %0d expected 0", T); end
    checks++; if (B !== 1'b0) begin errors++; $display("FAIL reset_B: got %0d expected 0", B); end
    checks++; if (streak !== 5'd0) begin errors++; $display("FAIL reset_streak: got %0d expected 0", streak); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %0d expected 0", game_over); end
    checks++; if (winner !== 2'd0) begin errors++; $display("FAIL reset_winner: got %0d expected 0", winner); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_t [3];
    exp_t[0] = 2'd1; exp_t[1] = 2'd2; exp_t[2] = 2'd0;
    do_reset();
    begin_game(2'd2);
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL rot_start_T: got %0d expected 0", T); end
    for (int i = 0; i < 3; i++) begin
      flip = 1'b1; match = 1'b0;
      step();
      flip = 1'b0;
      checks++; if (B !== 1'b0) begin errors++; $display("FAIL rot_B_%0d: got %0d expected 0", i, B); end
      step();
      checks++; if (T !== exp_t[i]) begin errors++; $display("FAIL rot_T_%0d: got %0d expected %0d", i, T, exp_t[i]); end
    end
  endtask

  task automatic test_streak();
    do_reset();
    begin_game(2'd3);
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    checks++; if (B !== 1'b1) begin errors++; $display("FAIL streak_B1: got %0d expected 1", B); end
    checks++; if (streak !== 5'd1) begin errors++; $display("FAIL streak_1: got %0d expected 1", streak); end
    // W raised during ADV must be ignored.
    W = 1'b1;
    step();
    W = 1'b0;
    checks++; if (B !== 1'b0) begin errors++; $display("FAIL streak_B_drop: got %0d expected 0", B); end
    step();
    step();
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    checks++; if (B !== 1'b1) begin errors++; $display("FAIL streak_B2: got %0d expected 1", B); end
    checks++; if (streak !== 5'd2) begin errors++; $display("FAIL streak_2: got %0d expected 2", streak); end
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL streak_T0: got %0d expected 0", T); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL streak_no_win: got %0d expected 0", game_over); end
    step();
    step();
    flip = 1'b1; match = 1'b0;
    step();
    flip = 1'b0;
    step();
    checks++; if (T !== 2'd1) begin errors++; $display("FAIL streak_miss_T: got %0d expected 1", T); end
    checks++; if (streak !== 5'd0) begin errors++; $display("FAIL streak_clear: got %0d expected 0", streak); end
  endtask

  task automatic test_timeout();
    logic [1:0] exp_t;
    do_reset();
    begin_game(2'd1);
    exp_t = 2'd0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 5; c++) step();
      checks++; if (T !== exp_t) begin errors++; $display("FAIL tmo_hold_%0d: got %0d expected %0d", k, T, exp_t); end
      step();
      exp_t = exp_t ^ 2'd1;
      checks++; if (T !== exp_t) begin errors++; $display("FAIL tmo_adv_%0d: got %0d expected %0d", k, T, exp_t); end
    end
    // Now in WAIT with timer 0 and T=0; the fifth WAIT cycle is the timeout cycle.
    for (int c = 0; c < 4; c++) step();
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    checks++; if (B !== 1'b1) begin errors++; $display("FAIL tmo_flip_B: got %0d expected 1", B); end
    step();
    step();
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL tmo_flip_T: got %0d expected 0", T); end
    step();
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL tmo_no_pass: got %0d expected 0", T); end
  endtask

  task automatic test_win();
    do_reset();
    begin_game(2'd2);
    flip = 1'b1; match = 1'b0;
    step();
    flip = 1'b0;
    step();
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    step();
    W = 1'b1;
    step();
    W = 1'b0;
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL win_over: got %0d expected 1", game_over); end
    checks++; if (winner !== 2'd1) begin errors++; $display("FAIL win_winner: got %0d expected 1", winner); end
    checks++; if (T !== 2'd1) begin errors++; $display("FAIL win_T_held: got %0d expected 1", T); end
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    checks++; if (B !== 1'b0) begin errors++; $display("FAIL win_flip_ignored: got %0d expected 0", B); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL win_over_held: got %0d expected 1", game_over); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL win_restart_over: got %0d expected 0", game_over); end
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL win_restart_T: got %0d expected 0", T); end
    checks++; if (winner !== 2'd0) begin errors++; $display("FAIL win_restart_winner: got %0d expected 0", winner); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    begin_game(2'd3);
    flip = 1'b1; match = 1'b0;
    step();
    flip = 1'b0;
    step();
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    checks++; if (B !== 1'b1) begin errors++; $display("FAIL mid_B_pre: got %0d expected 1", B); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (B !== 1'b0) begin errors++; $display("FAIL mid_B: got %0d expected 0", B); end
    checks++; if (T !== 2'd0) begin errors++; $display("FAIL mid_T: got %0d expected 0", T); end
    checks++; if (streak !== 5'd0) begin errors++; $display("FAIL mid_streak: got %0d expected 0", streak); end
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    checks++; if (B !== 1'b0) begin errors++; $display("FAIL mid_idle_flip: got %0d expected 0", B); end
    // Reset and start together: reset wins, so the sequencer stays idle.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    flip = 1'b1; match = 1'b1;
    step();
    flip = 1'b0;
    checks++; if (B !== 1'b0) begin errors++; $display("FAIL mid_rst_over_start: got %0d expected 0", B); end
  endtask

  task automatic test_two_players();
    logic [1:0] exp_t;
    do_reset();
    begin_game(2'd0);
    exp_t = 2'd0;
    for (int i = 0; i < 3; i++) begin
      flip = 1'b1; match = 1'b0;
      step();
      flip = 1'b0;
      step();
      exp_t = exp_t ^ 2'd1;
      checks++; if (T !== exp_t) begin errors++; $display("FAIL two_T_%0d: got %0d expected %0d", i, T, exp_t); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; num_players = 2'd0; flip = 1'b0; match = 1'b0; W = 1'b0;
    test_reset();
    test_rotation();
    test_streak();
    test_timeout();
    test_win();
    test_reset_mid();
    test_two_players();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
